// File: rtl/conv_result_writer_pkg.sv
// Shared constants for the convolution memory-control path.
// The state encodings are common to the read-address and result-writer FSMs.
package conv_result_writer_pkg;

  localparam int ADDR_SIZE  = 8;
  localparam int DATA_WIDTH = 16;
  localparam int IN_WIDTH   = 24;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_WRITE = 2'd1,
    WR_DONE  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/conv_wr_addr_gen.sv
// Row-major tile address generator for the result writer.
// load snaps the tile geometry and restarts at (0,0).
// step advances one element.
// last flags the final element of the tile.
module conv_wr_addr_gen
  import conv_result_writer_pkg::*;
#(
  parameter int addrSize = ADDR_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic [addrSize-1:0] base,
  input  logic [addrSize-1:0] stride,
  input  logic [addrSize-1:0] cols,
  input  logic [addrSize-1:0] rows,
  output logic [addrSize-1:0] addr,
  output logic                last
);

  localparam logic [addrSize-1:0] ONE = addrSize'(1);

  logic [addrSize-1:0] col, row, row_base;
  logic [addrSize-1:0] cols_q, rows_q, stride_q;
  logic                col_end, row_end;

  assign col_end = (col == cols_q - ONE);
  assign row_end = (row == rows_q - ONE);
  assign last    = col_end && row_end;

  // Geometry latch plus col/row/row-base/address counters; all sums wrap mod 2^addrSize.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
      addr     <= '0;
      cols_q   <= '0;
      rows_q   <= '0;
      stride_q <= '0;
    end else if (load) begin
      col      <= '0;
      row      <= '0;
      row_base <= base;
      addr     <= base;
      cols_q   <= cols;
      rows_q   <= rows;
      stride_q <= stride;
    end else if (step) begin
      if (!col_end) begin
        col  <= col + ONE;
        addr <= addr + ONE;
      end else if (!row_end) begin
        col      <= '0;
        row      <= row + ONE;
        row_base <= row_base + stride_q;
        addr     <= row_base + stride_q;
      end
    end
  end

endmodule

// File: rtl/conv_result_writer.sv
// Convolution result writer.
// Accepts a valid/ready result stream and writes it row-major into the output buffer.
// The tile sits at base, with stride between rows.
// Optional macro CONV_WR_SAT_EN saturates results to the signed write width instead of
// truncating them, and adds a sat_flag output.
module conv_result_writer
  import conv_result_writer_pkg::*;
#(
  parameter int addrSize  = ADDR_SIZE,
  parameter int dataWidth = DATA_WIDTH,
  parameter int inWidth   = IN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [addrSize-1:0]  base,
  input  logic [addrSize-1:0]  stride,
  input  logic [addrSize-1:0]  cols,
  input  logic [addrSize-1:0]  rows,
  input  logic                 in_valid,
  input  logic [inWidth-1:0]   in_data,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [addrSize-1:0]  mem_addr,
  output logic [dataWidth-1:0] mem_wdata,
`ifdef CONV_WR_SAT_EN
  output logic                 sat_flag,
`endif
  output logic                 busy,
  output logic                 done
);

  wr_state_e           state, state_nx;
  logic                load, accept, last;
  logic [addrSize-1:0] addr;
  logic [dataWidth-1:0] wdata_nx;

  conv_wr_addr_gen #(.addrSize(addrSize)) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (accept),
    .base   (base),
    .stride (stride),
    .cols   (cols),
    .rows   (rows),
    .addr   (addr),
    .last   (last)
  );

  assign accept = in_valid && in_ready;

`ifdef CONV_WR_SAT_EN
  localparam logic signed [inWidth-1:0] SMAX =
    {{(inWidth-dataWidth+1){1'b0}}, {(dataWidth-1){1'b1}}};
  localparam logic signed [inWidth-1:0] SMIN =
    {{(inWidth-dataWidth+1){1'b1}}, {(dataWidth-1){1'b0}}};
  logic sat_hi, sat_lo;

  // Clamp the accumulator value into the signed write range.
  always_comb begin
    sat_hi   = $signed(in_data) > SMAX;
    sat_lo   = $signed(in_data) < SMIN;
    wdata_nx = dataWidth'(in_data);
    if (sat_hi)      wdata_nx = {1'b0, {(dataWidth-1){1'b1}}};
    else if (sat_lo) wdata_nx = {1'b1, {(dataWidth-1){1'b0}}};
  end

  // Saturation indicator travels with the write strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sat_flag <= 1'b0;
    else      sat_flag <= accept && (sat_hi || sat_lo);
  end
`else
  assign wdata_nx = dataWidth'(in_data);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WR_IDLE;
    else      state <= state_nx;
  end

  // Next-state and handshake/status decode.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      WR_IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = (cols == '0 || rows == '0) ? WR_DONE : WR_WRITE;
        end
      end
      WR_WRITE: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && last) state_nx = WR_DONE;
      end
      WR_DONE: begin
        done     = 1'b1;
        state_nx = WR_IDLE;
      end
      default: state_nx = WR_IDLE;
    endcase
  end

  // Write port register: one cycle from accept to write; address/data hold between writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= accept;
      if (accept) begin
        mem_addr  <= addr;
        mem_wdata <= wdata_nx;
      end
    end
  end

endmodule

// File: tb/tb_conv_result_writer.sv
// Directed bench for conv_result_writer (default and CONV_WR_SAT_EN builds).
module tb_conv_result_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base, stride, cols, rows;
  logic        in_valid;
  logic [23:0] in_data;
  logic        in_ready, mem_we, busy, done;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
`ifdef CONV_WR_SAT_EN
  logic        sat_flag;
`endif

  int checks = 0;
  int errors = 0;

  conv_result_writer #(.addrSize(8), .dataWidth(16), .inWidth(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base      (base),
    .stride    (stride),
    .cols      (cols),
    .rows      (rows),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
`ifdef CONV_WR_SAT_EN
    .sat_flag  (sat_flag),
`endif
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; return at the following falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic begin_tile(input logic [7:0] b, input logic [7:0] s,
                            input logic [7:0] c, input logic [7:0] r);
    base = b; stride = s; cols = c; rows = r; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [7:0] exp_a [6];
  logic [7:0] wrap_a [4];

  initial begin
    exp_a  = '{8'h10, 8'h11, 8'h12, 8'h18, 8'h19, 8'h1A};
    wrap_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    rst = 1'b0; start = 1'b0; base = '0; stride = '0; cols = '0; rows = '0;
    in_valid = 1'b0; in_data = '0;

    // Reset state
    @(negedge clk);
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    rst = 1'b1;
    tick();

    // 3x2 tile, in_valid held high
    in_valid = 1'b1; in_data = 24'd1;
    begin_tile(8'h10, 8'd8, 8'd3, 8'd2);
    chk("t1_busy", busy, 1);
    chk("t1_in_ready", in_ready, 1);
    chk("t1_we_pre", mem_we, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t1_we", mem_we, 1);
      chk("t1_addr", mem_addr, exp_a[i]);
      chk("t1_data", mem_wdata, i + 1);
      chk("t1_done", done, (i == 5) ? 1 : 0);
      in_data = 24'(i + 2);
    end
    in_valid = 1'b0;
    chk("t1_ready_done", in_ready, 0);
    tick();
    chk("t1_done_off", done, 0);
    chk("t1_we_off", mem_we, 0);
    chk("t1_busy_off", busy, 0);

    // Same tile, in_valid toggled
    begin_tile(8'h10, 8'd8, 8'd3, 8'd2);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 24'(i + 1);
      tick();
      chk("t2_we", mem_we, 1);
      chk("t2_addr", mem_addr, exp_a[i]);
      chk("t2_data", mem_wdata, i + 1);
      chk("t2_done", done, (i == 5) ? 1 : 0);
      in_valid = 1'b0;
      tick();
      chk("t2_gap_we", mem_we, 0);
      chk("t2_gap_addr", mem_addr, exp_a[i]);
      chk("t2_gap_done", done, 0);
    end

    // Address wrap
    begin_tile(8'hFE, 8'h10, 8'd4, 8'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 24'(8'hA0 + i);
      tick();
      chk("t3_addr", mem_addr, wrap_a[i]);
      chk("t3_data", mem_wdata, 8'hA0 + i);
    end
    chk("t3_done", done, 1);
    in_valid = 1'b0;
    tick();

    // Empty tile; start during DONE is ignored
    begin_tile(8'h20, 8'd1, 8'd0, 8'd5);
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 0);
    chk("t4_we", mem_we, 0);
    chk("t4_in_ready", in_ready, 0);
    base = 8'h30; cols = 8'd2; rows = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_done_off", done, 0);
    chk("t4_busy_ignored", busy, 0);
    chk("t4_we_after", mem_we, 0);
    tick();

    // Mid-tile asynchronous reset, then restart at a new base
    begin_tile(8'h40, 8'd4, 8'd3, 8'd2);
    in_valid = 1'b1; in_data = 24'd9;
    tick();
    in_data = 24'd10;
    tick();
    chk("t5_we_2nd", mem_we, 1);
    chk("t5_addr_2nd", mem_addr, 8'h41);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_we", mem_we, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ready", in_ready, 0);
    chk("t5_rst_addr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("t5_idle_we", mem_we, 0);
    begin_tile(8'h80, 8'd2, 8'd2, 8'd1);
    in_valid = 1'b1; in_data = 24'd7;
    tick();
    chk("t5_new_addr0", mem_addr, 8'h80);
    chk("t5_new_data0", mem_wdata, 7);
    in_data = 24'd8;
    tick();
    chk("t5_new_addr1", mem_addr, 8'h81);
    chk("t5_new_done", done, 1);
    in_valid = 1'b0;
    tick();

    // Saturation / truncation of wide results
    begin_tile(8'h00, 8'd0, 8'd3, 8'd1);
    in_valid = 1'b1; in_data = 24'h009000;
    tick();
`ifdef CONV_WR_SAT_EN
    chk("t6_pos_data", mem_wdata, 16'h7FFF);
    chk("t6_pos_flag", sat_flag, 1);
`else
    chk("t6_pos_data", mem_wdata, 16'h9000);
`endif
    in_data = 24'hFF0000;
    tick();
`ifdef CONV_WR_SAT_EN
    chk("t6_neg_data", mem_wdata, 16'h8000);
    chk("t6_neg_flag", sat_flag, 1);
`else
    chk("t6_neg_data", mem_wdata, 16'h0000);
`endif
    in_data = 24'hFFFF85;
    tick();
    chk("t6_inrange_data", mem_wdata, 16'hFF85);
`ifdef CONV_WR_SAT_EN
    chk("t6_inrange_flag", sat_flag, 0);
`endif
    chk("t6_done", done, 1);
    in_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
